// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   mst_id_t   : identifies one of the NUM_MST masters (0 = core LSU, 1 = AES LSU)
//   NUM_MST    : number of masters sharing the memory port
//   obi_req_t  : request-channel payload {addr, we, be, wdata} at the default
//                32-bit bus geometry
//   obi_rsp_t  : response-channel payload {rdata, err} at the default geometry
//   ptr_width  : pointer width for a FIFO of a given depth (never below 1)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef logic mst_id_t;

    localparam int NUM_MST    = 2;
    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// ---------------------------------------------------------------------------
// arb_id_fifo
// In-order FIFO of master IDs, one entry per accepted memory request. The
// head entry says which master the next memory response belongs to.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (clears count and both pointers)
//   push   : write din (ignored when full)
//   pop    : drop the head entry (ignored when empty)
//   din    : master ID to store
//   dout   : master ID at the head (valid when ~empty)
//   full   : DEPTH entries stored
//   empty  : no entries stored
// ---------------------------------------------------------------------------
module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push,
    input  logic    pop,
    input  mst_id_t din,
    output mst_id_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    mst_id_t          id_mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push, do_pop;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = id_mem_reg[rd_ptr_reg];

    // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            id_mem_reg[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one OBI-style data-memory port between the core LSU (m0) and the AES
// coprocessor LSU (m1). Round-robin between simultaneous requesters; once a
// request is presented and stalled it is locked until granted, so the
// downstream address/data stay stable. Each accepted request pushes its
// master ID into an in-order FIFO that steers the matching response back.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   mN_req_i / mN_gnt_o      : master request / same-cycle acceptance
//   mN_addr_i, mN_we_i,
//   mN_be_i, mN_wdata_i      : master request payload
//   mN_rvalid_o, mN_rdata_o,
//   mN_err_o                 : master response (rdata shared by both)
//   mem_req_o / mem_gnt_i    : downstream request handshake
//   mem_addr_o, mem_we_o,
//   mem_be_o, mem_wdata_o    : downstream request payload (from selected master)
//   mem_rvalid_i, mem_rdata_i,
//   mem_err_i                : downstream response
//   unexp_rsp_o              : sticky; a response came with nothing outstanding
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2    // legal range 1..8
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                m0_req_i,
    output logic                m0_gnt_o,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_err_o,

    input  logic                m1_req_i,
    output logic                m1_gnt_o,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_err_o,

    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_err_i,

    output logic                unexp_rsp_o
);

    localparam int BE_W = DATA_W / 8;

    // Same field order as obi_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mst_id_t prio_reg, prio_next;
    logic    lock_vld_reg, lock_vld_next;
    mst_id_t lock_id_reg, lock_id_next;
    logic    unexp_rsp_reg, unexp_rsp_next;

    // ------------------------------------------------------------------
    // Per-master views
    // ------------------------------------------------------------------
    logic [NUM_MST-1:0] req;
    logic [NUM_MST-1:0] gnt;
    logic [NUM_MST-1:0] rvalid;
    logic [NUM_MST-1:0] err;
    bus_req_t           bus [NUM_MST];

    assign req    = {m1_req_i, m0_req_i};
    assign bus[0] = {m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i};
    assign bus[1] = {m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i};

    // ------------------------------------------------------------------
    // Selection: a stalled request keeps the port; otherwise a lone
    // requester wins, and a tie goes to the round-robin favourite.
    // ------------------------------------------------------------------
    mst_id_t  sel;
    bus_req_t sel_bus;

    always_comb begin
        sel = prio_reg;
        if (lock_vld_reg) begin
            sel = lock_id_reg;
        end else if (req[0] & ~req[1]) begin
            sel = 1'b0;
        end else if (req[1] & ~req[0]) begin
            sel = 1'b1;
        end
    end

    assign sel_bus = bus[sel];

    // ------------------------------------------------------------------
    // Outstanding-ID FIFO
    // ------------------------------------------------------------------
    logic    fifo_full, fifo_empty;
    mst_id_t fifo_head;
    logic    handshake;
    logic    rsp_take;

    // A full FIFO blocks new requests even if a response frees a slot in
    // the same cycle; this keeps mem_req_o independent of mem_rvalid_i.
    assign mem_req_o = (|req) & ~fifo_full;
    assign handshake = mem_req_o & mem_gnt_i;
    assign rsp_take  = mem_rvalid_i & ~fifo_empty;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (handshake),
        .pop    (rsp_take),
        .din    (sel),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Downstream payload
    // ------------------------------------------------------------------
    assign mem_addr_o  = sel_bus.addr;
    assign mem_we_o    = sel_bus.we;
    assign mem_be_o    = sel_bus.be;
    assign mem_wdata_o = sel_bus.wdata;

    // ------------------------------------------------------------------
    // Grant and response steering; both are forced low while in reset.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
            assign gnt[gi]    = handshake & (sel == mst_id_t'(gi)) & rst_ni;
            assign rvalid[gi] = rsp_take & (fifo_head == mst_id_t'(gi)) & rst_ni;
            assign err[gi]    = rvalid[gi] & mem_err_i;
        end
    endgenerate

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_err_o    = err[0];
    assign m1_err_o    = err[1];
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign unexp_rsp_o = unexp_rsp_reg;

    // ------------------------------------------------------------------
    // Arbitration state update
    // ------------------------------------------------------------------
    always_comb begin
        prio_next      = prio_reg;
        lock_vld_next  = lock_vld_reg;
        lock_id_next   = lock_id_reg;
        unexp_rsp_next = unexp_rsp_reg | (mem_rvalid_i & fifo_empty);
        if (handshake) begin
            // The master just served yields priority to the other one.
            prio_next     = ~sel;
            lock_vld_next = 1'b0;
        end else if (mem_req_o) begin
            // Stalled: pin the choice so the request stays stable.
            lock_vld_next = 1'b1;
            lock_id_next  = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_reg      <= 1'b0;
            lock_vld_reg  <= 1'b0;
            lock_id_reg   <= 1'b0;
            unexp_rsp_reg <= 1'b0;
        end else begin
            prio_reg      <= prio_next;
            lock_vld_reg  <= lock_vld_next;
            lock_id_reg   <= lock_id_next;
            unexp_rsp_reg <= unexp_rsp_next;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Cycle-by-cycle vector table for data_mem_arbiter followed by a hand-written
// sequence with a 3-cycle response latency that fills the ID FIFO.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam logic [31:0] A0  = 32'h0000_0188;
    localparam logic [31:0] A1  = 32'h0000_018C;
    localparam logic [31:0] WD0 = 32'h0BAD_F00D;
    localparam logic [31:0] WD1 = 32'h1234_5678;

    logic        clk;
    logic        rst_ni;
    logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_err_o, m1_err_o;
    logic        mem_req_o, mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        unexp_rsp_o;

    data_mem_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .m0_req_i     (m0_req_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_addr_i    (m0_addr_i),
        .m0_we_i      (m0_we_i),
        .m0_be_i      (m0_be_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_err_o     (m0_err_o),
        .m1_req_i     (m1_req_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_addr_i    (m1_addr_i),
        .m1_we_i      (m1_we_i),
        .m1_be_i      (m1_be_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_err_o     (m1_err_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .unexp_rsp_o  (unexp_rsp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [1:0]  req;      // {m1, m0}
        logic [1:0]  we;       // {m1, m0}
        logic [3:0]  be1;
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_req;
        logic        e_sel;    // master whose payload should be on mem_*
        logic [1:0]  e_rvalid;
        logic [1:0]  e_err;
        logic        e_unexp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string name, input logic rst_n, input logic [1:0] req,
                       input logic [1:0] we, input logic [3:0] be1, input logic gnt,
                       input logic rvalid, input logic err, input logic [31:0] rdata,
                       input logic [1:0] e_gnt, input logic e_req, input logic e_sel,
                       input logic [1:0] e_rvalid, input logic [1:0] e_err,
                       input logic e_unexp);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.req = req; v.we = we; v.be1 = be1;
        v.gnt = gnt; v.rvalid = rvalid; v.err = err; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_req = e_req; v.e_sel = e_sel;
        v.e_rvalid = e_rvalid; v.e_err = e_err; v.e_unexp = e_unexp;
        vecs.push_back(v);
    endtask

    task automatic check(input string vname, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, want %0h", vname, field, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        rst_ni       = v.rst_n;
        m0_req_i     = v.req[0];
        m1_req_i     = v.req[1];
        m0_we_i      = v.we[0];
        m1_we_i      = v.we[1];
        m1_be_i      = v.be1;
        mem_gnt_i    = v.gnt;
        mem_rvalid_i = v.rvalid;
        mem_err_i    = v.err;
        mem_rdata_i  = v.rdata;
        #4;
        n_vec++;
        e_addr  = v.e_sel ? A1 : A0;
        e_we    = v.e_sel ? v.we[1] : v.we[0];
        e_be    = v.e_sel ? v.be1 : 4'hF;
        e_wdata = v.e_sel ? WD1 : WD0;
        check(v.name, "gnt", {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, v.e_gnt});
        check(v.name, "mem_req", {31'd0, mem_req_o}, {31'd0, v.e_req});
        check(v.name, "rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, {30'd0, v.e_rvalid});
        check(v.name, "err", {30'd0, m1_err_o, m0_err_o}, {30'd0, v.e_err});
        check(v.name, "unexp", {31'd0, unexp_rsp_o}, {31'd0, v.e_unexp});
        if (v.e_req) begin
            check(v.name, "addr", mem_addr_o, e_addr);
            check(v.name, "we", {31'd0, mem_we_o}, {31'd0, e_we});
            check(v.name, "be", {28'd0, mem_be_o}, {28'd0, e_be});
            check(v.name, "wdata", mem_wdata_o, e_wdata);
        end
        if (v.e_rvalid != 2'b00) begin
            check(v.name, "m0_rdata", m0_rdata_o, v.rdata);
            check(v.name, "m1_rdata", m1_rdata_o, v.rdata);
        end
        $display("vec %-12s req=%b gnt=%b%b mem_req=%b addr=%h rvalid=%b%b unexp=%b",
                 v.name, v.req, m1_gnt_o, m0_gnt_o, mem_req_o, mem_addr_o,
                 m1_rvalid_o, m0_rvalid_o, unexp_rsp_o);
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle behaviour with m0 requesting every cycle (c0..c8),
    // grant always high, and each response returned 3 cycles after its grant.
    // Grants land at c0,c1,c4,c5,c8; responses at c3,c4,c7,c8,c11.
    logic [11:0] full_exp_req = 12'b0001_0011_0011;  // bit c
    logic [11:0] full_exp_rv  = 12'b1001_1001_1000;

    initial begin
        int due[$];
        int rsp_sent;
        int rsp_seen;

        rst_ni = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        m0_addr_i = A0; m1_addr_i = A1;
        m0_we_i = 1'b0; m1_we_i = 1'b0;
        m0_be_i = 4'hF; m1_be_i = 4'hF;
        m0_wdata_i = WD0; m1_wdata_i = WD1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        @(posedge clk);
        #1;

        //   name           rst req  we    be1   gnt rv err rdata           e_gnt ereq sel e_rv  e_err unexp
        add("rst",          0, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 0);
        add("rd0",          1, 2'b01, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b01, 1, 0, 2'b00, 2'b00, 0);
        add("rd0_rsp",      1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'hDEADBEEF,   2'b00, 0, 0, 2'b01, 2'b00, 0);
        add("rst2",         0, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 0);
        add("rr0",          1, 2'b11, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b01, 1, 0, 2'b00, 2'b00, 0);
        add("rr1",          1, 2'b11, 2'b00, 4'hF, 1, 1, 0, 32'hA0,         2'b10, 1, 1, 2'b01, 2'b00, 0);
        add("rr2",          1, 2'b11, 2'b00, 4'hF, 1, 1, 0, 32'hA1,         2'b01, 1, 0, 2'b10, 2'b00, 0);
        add("rr3",          1, 2'b11, 2'b00, 4'hF, 1, 1, 0, 32'hA2,         2'b10, 1, 1, 2'b01, 2'b00, 0);
        add("rr_drain",     1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'hA3,         2'b00, 0, 0, 2'b10, 2'b00, 0);
        add("hold0",        1, 2'b11, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0);
        add("hold1",        1, 2'b11, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0);
        add("hold2",        1, 2'b11, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0);
        add("hold_gnt",     1, 2'b01, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b01, 1, 0, 2'b00, 2'b00, 0);
        add("err_rsp",      1, 2'b00, 2'b00, 4'hF, 0, 1, 1, 32'hE0,         2'b00, 0, 0, 2'b01, 2'b01, 0);
        add("m1_hs",        1, 2'b10, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b10, 1, 1, 2'b00, 2'b00, 0);
        add("lock_m1",      1, 2'b10, 2'b00, 4'hF, 0, 1, 0, 32'hB0,         2'b00, 1, 1, 2'b10, 2'b00, 0);
        add("lock_hold",    1, 2'b11, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 1, 1, 2'b00, 2'b00, 0);
        add("lock_gnt",     1, 2'b11, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b10, 1, 1, 2'b00, 2'b00, 0);
        add("m0_wait",      1, 2'b01, 2'b00, 4'hF, 0, 1, 0, 32'hB1,         2'b00, 1, 0, 2'b10, 2'b00, 0);
        add("m0_gnt",       1, 2'b01, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b01, 1, 0, 2'b00, 2'b00, 0);
        add("m0_rsp",       1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'hB2,         2'b00, 0, 0, 2'b01, 2'b00, 0);
        add("wr_m1",        1, 2'b10, 2'b10, 4'h3, 1, 0, 0, 32'h0,          2'b10, 1, 1, 2'b00, 2'b00, 0);
        add("wr_rsp",       1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'h0,          2'b00, 0, 0, 2'b10, 2'b00, 0);
        add("unexp_pulse",  1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'h55,         2'b00, 0, 0, 2'b00, 2'b00, 0);
        add("unexp_set",    1, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 1);
        add("unexp_hold",   1, 2'b01, 2'b00, 4'hF, 1, 0, 0, 32'h0,          2'b01, 1, 0, 2'b00, 2'b00, 1);
        add("rst_mid",      0, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 1);
        add("rst_clr",      1, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 0);
        add("stale_rsp",    1, 2'b00, 2'b00, 4'hF, 0, 1, 0, 32'h77,         2'b00, 0, 0, 2'b00, 2'b00, 0);
        add("stale_set",    1, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 1);
        add("rst3",         0, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 1);
        add("post_rst",     1, 2'b00, 2'b00, 4'hF, 0, 0, 0, 32'h0,          2'b00, 0, 0, 2'b00, 2'b00, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // FIFO-full back-pressure with delayed responses.
        rsp_sent = 0;
        rsp_seen = 0;
        m1_req_i  = 1'b0;
        m0_we_i   = 1'b0;
        mem_err_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            m0_req_i     = (c <= 8);
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (due.size() > 0) && (due[0] == c);
            mem_rdata_i  = 32'h100 + rsp_sent;
            #4;
            n_vec++;
            check($sformatf("full_c%0d", c), "mem_req", {31'd0, mem_req_o}, {31'd0, full_exp_req[c]});
            check($sformatf("full_c%0d", c), "m0_gnt", {31'd0, m0_gnt_o}, {31'd0, full_exp_req[c]});
            check($sformatf("full_c%0d", c), "m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, full_exp_rv[c]});
            check($sformatf("full_c%0d", c), "m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
            if (m0_rvalid_o) begin
                check($sformatf("full_c%0d", c), "order", m0_rdata_o, 32'h100 + rsp_seen);
                rsp_seen++;
            end
            $display("full c%0d req=%b gnt=%b rvalid=%b rdata=%h", c, mem_req_o,
                     m0_gnt_o, m0_rvalid_o, m0_rdata_o);
            if (mem_rvalid_i) begin
                void'(due.pop_front());
                rsp_sent++;
            end
            if (m0_gnt_o) due.push_back(c + 3);
            @(posedge clk);
            #1;
        end
        n_vec++;
        check("full_total", "responses", rsp_seen, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
